// File: rtl/atom_bus_pkg.sv
// Shared types and constants for the Atom bus initiator: FSM states, rombox
// register addresses, RW polarity and the phase-counter width.
package atom_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH1   = 3'd1,
        ST_PH2   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_VPH1  = 3'd4,
        ST_VPH2  = 3'd5,
        ST_VHOLD = 3'd6,
        ST_DONE  = 3'd7
    } atom_state_e;

    localparam logic [15:0] ROMLATCH_ADDR = 16'hBFFF;
    localparam logic [15:0] SWLATCH_ADDR  = 16'hBFFE;
    localparam logic [15:0] JUMPER_ADDR   = 16'hBFFD;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int PHASE_CNT_W = 4;

    function automatic bit phase_clks_ok(input int p);
        return (p >= 2) && (p <= 15);
    endfunction

endpackage

// File: rtl/atom_bus_if.sv
// 6502-style Atom bus as seen by the RAM/ROM box: the initiator drives the
// master side, the responder (or its model) the slave side.
interface atom_bus_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);

    logic [ADDR_W-1:0] Addr;
    logic              RW;
    logic              PHI2;
    logic [DATA_W-1:0] DataOut;
    logic              DataOE;
    logic [DATA_W-1:0] DataIn;

    modport master (
        output Addr,
        output RW,
        output PHI2,
        output DataOut,
        output DataOE,
        input  DataIn
    );

    modport slave (
        input  Addr,
        input  RW,
        input  PHI2,
        input  DataOut,
        input  DataOE,
        output DataIn
    );

endinterface

// File: rtl/atom_phase_timer.sv
// Loadable down-counter shared by every PHI2 phase state; tc is high while
// the count sits at zero, i.e. on the last Clk of the current phase.
import atom_bus_pkg::*;

module atom_phase_timer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic                   tc
);

    logic [PHASE_CNT_W-1:0] cnt_q;
    logic [PHASE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/atom_bus_initiator.sv
// Atom bus cycle generator: turns single Req/Ack requests into PHI1/PHI2 bus
// cycles. Define ATOM_BUS_VERIFY_EN to add an automatic read-back after writes.
import atom_bus_pkg::*;

module atom_bus_initiator #(
    parameter int PHASE_CLKS = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
) (
    input  logic              Clk,
    input  logic              NReset,
    input  logic              Req,
    input  logic              ReqRW,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              Ack,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic              VerifyErr,
    atom_bus_if.master        bus,
    output atom_state_e       DbgState
);

    if (!phase_clks_ok(PHASE_CLKS)) begin : g_bad_phase_clks
        $error("atom_bus_initiator: PHASE_CLKS must be within 2..15");
    end

    localparam logic [PHASE_CNT_W-1:0] PHASE_RELOAD = PHASE_CNT_W'(PHASE_CLKS - 1);

    // Req/Ack handshake: Req is only looked at in IDLE; the edge that sees it
    // high accepts the request and raises Busy, which stays high through the
    // single-Clk Ack pulse. Req seen outside IDLE is dropped, never queued.

    atom_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic              phi2_q, phi2_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doe_q, doe_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmr_load;
    logic              tmr_tc;
`ifdef ATOM_BUS_VERIFY_EN
    logic              verr_q, verr_d;
`endif

    atom_phase_timer u_timer (
        .clk      (Clk),
        .rst_n    (NReset),
        .load     (tmr_load),
        .load_val (PHASE_RELOAD),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        phi2_d   = phi2_q;
        dout_d   = dout_q;
        doe_d    = doe_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        tmr_load = 1'b0;
`ifdef ATOM_BUS_VERIFY_EN
        verr_d   = verr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    addr_d   = ReqAddr;
                    rw_d     = ReqRW;
                    dout_d   = ReqWData;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_PH1;
                end
            end
            ST_PH1: begin
                if (tmr_tc) begin
                    phi2_d   = 1'b1;
                    doe_d    = (rw_q == RW_WRITE);
                    tmr_load = 1'b1;
                    state_d  = ST_PH2;
                end
            end
            ST_PH2: begin
                if (tmr_tc) begin
                    phi2_d  = 1'b0;
                    state_d = ST_HOLD;
                    if (rw_q == RW_READ) begin
                        rdata_d = bus.DataIn;
                    end
                end
            end
            ST_HOLD: begin
                // Address, RW and data stay put for this Clk so the
                // responder's falling-PHI2 latches see clean hold time.
                doe_d = 1'b0;
`ifdef ATOM_BUS_VERIFY_EN
                if (rw_q == RW_WRITE) begin
                    rw_d     = RW_READ;
                    tmr_load = 1'b1;
                    state_d  = ST_VPH1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
`else
                ack_d   = 1'b1;
                state_d = ST_DONE;
`endif
            end
`ifdef ATOM_BUS_VERIFY_EN
            ST_VPH1: begin
                if (tmr_tc) begin
                    phi2_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_VPH2;
                end
            end
            ST_VPH2: begin
                if (tmr_tc) begin
                    phi2_d  = 1'b0;
                    rdata_d = bus.DataIn;
                    if (bus.DataIn != dout_q) begin
                        verr_d = 1'b1;
                    end
                    state_d = ST_VHOLD;
                end
            end
            ST_VHOLD: begin
                ack_d   = 1'b1;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                rw_d    = RW_READ;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                phi2_d  = 1'b0;
                doe_d   = 1'b0;
                rw_d    = RW_READ;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rw_q    <= RW_READ;
            phi2_q  <= 1'b0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            phi2_q  <= phi2_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef ATOM_BUS_VERIFY_EN
    always_ff @(posedge Clk or negedge NReset) begin
        if (!NReset) begin
            verr_q <= 1'b0;
        end else begin
            verr_q <= verr_d;
        end
    end
    assign VerifyErr = verr_q;
`else
    assign VerifyErr = 1'b0;
`endif

    assign bus.Addr    = addr_q;
    assign bus.RW      = rw_q;
    assign bus.PHI2    = phi2_q;
    assign bus.DataOut = dout_q;
    assign bus.DataOE  = doe_q;
    assign Ack         = ack_q;
    assign Busy        = busy_q;
    assign RData       = rdata_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_atom_bus_initiator.sv
// Directed bench for atom_bus_initiator: a PHASE_CLKS=4 instance against a
// rombox model and a PHASE_CLKS=2 instance against a small RAM model.
import atom_bus_pkg::*;

module tb_atom_bus_initiator;

`ifdef ATOM_BUS_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int PA = 4;
    localparam int PB = 2;
    localparam int RD_LAT_A = 2 * PA + 2;
    localparam int WR_LAT_A = VER ? 4 * PA + 3 : 2 * PA + 2;
    localparam int RD_LAT_B = 2 * PB + 2;
    localparam int WR_LAT_B = VER ? 4 * PB + 3 : 2 * PB + 2;
    localparam int PHI_HI_WA = VER ? 2 * PA : PA;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (PHASE_CLKS=4) ----------------
    logic        a_req = 1'b0, a_rw = 1'b1;
    logic [15:0] a_addr = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_ack, a_busy, a_verr;
    logic [7:0]  a_rdata;
    atom_state_e a_state;
    atom_bus_if #(.ADDR_W(16), .DATA_W(8)) if_a ();

    atom_bus_initiator #(.PHASE_CLKS(PA), .ADDR_W(16), .DATA_W(8)) u_dut_a (
        .Clk(clk), .NReset(rst_n), .Req(a_req), .ReqRW(a_rw), .ReqAddr(a_addr),
        .ReqWData(a_wdata), .Ack(a_ack), .RData(a_rdata), .Busy(a_busy),
        .VerifyErr(a_verr), .bus(if_a), .DbgState(a_state)
    );

    // ---------------- DUT B (PHASE_CLKS=2) ----------------
    logic        b_req = 1'b0, b_rw = 1'b1;
    logic [15:0] b_addr = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_ack, b_busy, b_verr;
    logic [7:0]  b_rdata;
    atom_state_e b_state;
    atom_bus_if #(.ADDR_W(16), .DATA_W(8)) if_b ();

    atom_bus_initiator #(.PHASE_CLKS(PB), .ADDR_W(16), .DATA_W(8)) u_dut_b (
        .Clk(clk), .NReset(rst_n), .Req(b_req), .ReqRW(b_rw), .ReqAddr(b_addr),
        .ReqWData(b_wdata), .Ack(b_ack), .RData(b_rdata), .Busy(b_busy),
        .VerifyErr(b_verr), .bus(if_b), .DbgState(b_state)
    );

    // ---------------- responder models ----------------
    logic [3:0] a_latch = 4'h0;
    logic [7:0] a_mem [256];
    logic [7:0] b_mem [256];
    logic [7:0] a_raw;
    bit         a_force_b0 = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 8'h00;
            b_mem[i] = 8'h00;
        end
    end

    always_comb begin
        a_raw = a_mem[if_a.Addr[7:0]];
        if (if_a.Addr == ROMLATCH_ADDR) a_raw = {4'h0, a_latch};
        else if (if_a.Addr == JUMPER_ADDR) a_raw = 8'h8C;
    end
    assign if_a.DataIn = if_a.RW ? (a_force_b0 ? (a_raw & 8'hFE) : a_raw) : 8'h00;
    assign if_b.DataIn = if_b.RW ? b_mem[if_b.Addr[7:0]] : 8'h00;

    // Responder latches capture on falling PHI2; a reset-forced fall is ignored.
    always @(negedge if_a.PHI2) begin
        if (rst_n && !if_a.RW && if_a.DataOE) begin
            if (if_a.Addr == ROMLATCH_ADDR) a_latch <= if_a.DataOut[3:0];
            else a_mem[if_a.Addr[7:0]] <= if_a.DataOut;
        end
    end
    always @(negedge if_b.PHI2) begin
        if (rst_n && !if_b.RW && if_b.DataOE) b_mem[if_b.Addr[7:0]] <= if_b.DataOut;
    end

    // ---------------- instance select ----------------
    bit sel = 1'b0;
    wire       m_ack   = sel ? b_ack   : a_ack;
    wire       m_busy  = sel ? b_busy  : a_busy;
    wire       m_phi2  = sel ? if_b.PHI2   : if_a.PHI2;
    wire       m_oe    = sel ? if_b.DataOE : if_a.DataOE;
    wire [7:0] m_rdata = sel ? b_rdata : a_rdata;
    wire       m_verr  = sel ? b_verr  : a_verr;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rdata(input string tag, input logic [7:0] got);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, exp_q.size(), 1);
        else check(tag, got, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input logic v, input logic rw, input logic [15:0] ad, input logic [7:0] wd);
        if (sel) begin
            b_req = v; b_rw = rw; b_addr = ad; b_wdata = wd;
        end else begin
            a_req = v; a_rw = rw; a_addr = ad; a_wdata = wd;
        end
    endtask

    // lat = edge at which a consumer first samples Ack high, minus the accept edge.
    task automatic run_cycle(input logic rw, input logic [15:0] ad, input logic [7:0] wd,
                             output int lat, output int phi_hi, output int oe_hi,
                             output logic busy_after, output logic [7:0] rd_at_ack);
        int t0;
        int n;
        @(negedge clk);
        set_req(1'b1, rw, ad, wd);
        t0 = cyc + 1;
        @(negedge clk);
        set_req(1'b0, ~rw, ~ad, ~wd);
        lat = -1; phi_hi = 0; oe_hi = 0; n = 0; rd_at_ack = 8'hxx;
        while (lat < 0 && n < 200) begin
            if (m_phi2) phi_hi++;
            if (m_oe) oe_hi++;
            if (m_ack) begin
                lat = cyc + 1 - t0;
                rd_at_ack = m_rdata;
            end
            n++;
            @(negedge clk);
        end
        busy_after = m_busy;
    endtask

    // ---------------- stimulus ----------------
    int lat, phi_hi, oe_hi, t0, n_ack, acc, acks, idle_between;
    logic busy_after, prev_busy;
    logic [7:0] rd;
    int ack_t[3];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr", if_a.Addr, 16'h0000);
        check("rst_rw", if_a.RW, 1'b1);
        check("rst_phi2", if_a.PHI2, 1'b0);
        check("rst_dout", if_a.DataOut, 8'h00);
        check("rst_doe", if_a.DataOE, 1'b0);
        check("rst_ack", a_ack, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_rdata", a_rdata, 8'h00);
        check("rst_verr", a_verr, 1'b0);
        check("rst_state", a_state, ST_IDLE);
        rst_n = 1'b1;

        // Write rombox bank latch
        sel = 1'b0;
        run_cycle(RW_WRITE, ROMLATCH_ADDR, 8'h03, lat, phi_hi, oe_hi, busy_after, rd);
        check("wr_lat", lat, WR_LAT_A);
        check("wr_phi2_hi", phi_hi, PHI_HI_WA);
        check("wr_oe_hi", oe_hi, PA + 1);
        check("wr_busy_after", busy_after, 1'b0);
        check("wr_latch", a_latch, 4'h3);
        check("wr_verr", a_verr, 1'b0);

        // Read jumper port
        exp_q.push_back(8'h8C);
        run_cycle(RW_READ, JUMPER_ADDR, 8'h00, lat, phi_hi, oe_hi, busy_after, rd);
        check("rd_lat", lat, RD_LAT_A);
        check_rdata("rd_rdata", rd);
        check("rd_oe_hi", oe_hi, 0);
        check("rd_phi2_hi", phi_hi, PA);
        check("rd_busy_after", busy_after, 1'b0);
        check("idle_addr_hold", if_a.Addr, JUMPER_ADDR);
        check("idle_rw", if_a.RW, 1'b1);

        // Req held high: three back-to-back reads
        repeat (3) exp_q.push_back(8'h8C);
        @(negedge clk);
        set_req(1'b1, RW_READ, JUMPER_ADDR, 8'h00);
        acc = 0; acks = 0; idle_between = 0; prev_busy = m_busy;
        for (int i = 0; i < 200 && acks < 3; i++) begin
            @(negedge clk);
            if (m_busy && !prev_busy) begin
                acc++;
                if (acc == 3) a_req = 1'b0;
            end
            if (m_ack) begin
                ack_t[acks] = cyc;
                acks++;
                check_rdata("b2b_rdata", m_rdata);
            end
            if (!m_busy && acc > 0 && acks < 3) idle_between++;
            prev_busy = m_busy;
        end
        a_req = 1'b0;
        check("b2b_acks", acks, 3);
        check("b2b_space1", ack_t[1] - ack_t[0], 2 * PA + 3);
        check("b2b_space2", ack_t[2] - ack_t[1], 2 * PA + 3);
        check("b2b_idle", idle_between, 2);
        repeat (2) @(negedge clk);

        // Reset in the 2nd Clk of PH2 of a write
        set_req(1'b1, RW_WRITE, ROMLATCH_ADDR, 8'h0A);
        t0 = cyc + 1;
        @(negedge clk);
        set_req(1'b0, RW_READ, 16'h0000, 8'h00);
        for (int i = 0; i < 50 && cyc < t0 + 5; i++) @(negedge clk);
        check("pre_rst_phi2", if_a.PHI2, 1'b1);
        check("pre_rst_oe", if_a.DataOE, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_phi2", if_a.PHI2, 1'b0);
        check("mid_rst_oe", if_a.DataOE, 1'b0);
        check("mid_rst_busy", a_busy, 1'b0);
        n_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        check("mid_rst_no_ack", n_ack, 0);
        check("mid_rst_latch", a_latch, 4'h3);
        rst_n = 1'b1;
        run_cycle(RW_WRITE, ROMLATCH_ADDR, 8'h05, lat, phi_hi, oe_hi, busy_after, rd);
        check("post_rst_lat", lat, WR_LAT_A);
        check("post_rst_latch", a_latch, 4'h5);

        // PHASE_CLKS=2 instance: write then read back RAM
        sel = 1'b1;
        run_cycle(RW_WRITE, 16'h0A00, 8'h5A, lat, phi_hi, oe_hi, busy_after, rd);
        check("p2_wr_lat", lat, WR_LAT_B);
        check("p2_wr_phi2_hi", phi_hi, VER ? 2 * PB : PB);
        check("p2_mem", b_mem[8'h00], 8'h5A);
        exp_q.push_back(8'h5A);
        run_cycle(RW_READ, 16'h0A00, 8'h00, lat, phi_hi, oe_hi, busy_after, rd);
        check("p2_rd_lat", lat, RD_LAT_B);
        check_rdata("p2_rdata", rd);
        check("p2_verr", m_verr, 1'b0);

        // Read-back verify with the model pulling bit 0 low on reads
        sel = 1'b0;
        a_force_b0 = 1'b1;
        run_cycle(RW_WRITE, 16'h2000, 8'hFF, lat, phi_hi, oe_hi, busy_after, rd);
        a_force_b0 = 1'b0;
        check("vfy_lat", lat, WR_LAT_A);
        check("vfy_err", a_verr, VER ? 1'b1 : 1'b0);
        check("vfy_rdata", rd, VER ? 8'hFE : 8'h00);
        repeat (2) @(negedge clk);
        check("vfy_err_sticky", a_verr, VER ? 1'b1 : 1'b0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atom_bus_initiator.md
Name: atom_bus_initiator

Overview:
- Bus-cycle generator that drives 6502-style Atom bus cycles into the RAM/ROM box: PHI2, RW, Addr, Data.
- Acts as the initiator side of the box's responder interface.
- Used by the config/boot loader to program the rombox bank latch ($BFFF) and switch latch ($BFFE), read the jumper port ($BFFD), and fill RAM or flash-backed RAM.
- Presents a simple single-request Req/Ack interface on the system clock.

Parameters:
- PHASE_CLKS, 4, Clk cycles per PHI2 phase (PHI1 low phase and PHI2 high phase each); legal values 2..15.
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- NReset  input  1  asynchronous active-low reset.
- Req  input  1  request strobe; sampled in IDLE only.
- ReqRW  input  1  1=read, 0=write (6502 polarity).
- ReqAddr  input  ADDR_W  target address.
- ReqWData  input  DATA_W  write data.
- Ack  output  1  one-Clk pulse on cycle completion.
- RData  output  DATA_W  read data; valid with Ack, held until the next read's Ack.
- Busy  output  1  high from request accept until Ack, inclusive.
- VerifyErr  output  1  sticky read-back mismatch flag (optional feature).
- Addr  output  ADDR_W  bus address.
- RW  output  1  bus read/write.
- PHI2  output  1  bus phase-2 clock; low when idle.
- DataOut  output  DATA_W  bus write data.
- DataOE  output  1  data-bus drive enable; the top level builds the tristate.
- DataIn  input  DATA_W  bus data in.

Behaviour:
- Reset values: Addr=0, RW=1, PHI2=0, DataOut=0, DataOE=0, Ack=0, Busy=0, RData=0, VerifyErr=0, state IDLE, phase counter=0.
- Reset is asynchronous at any point, including mid-cycle. PHI2 and DataOE drop immediately, no Ack is issued, and the partial cycle is abandoned.
- Registered outputs only; no combinational path from Req to the bus.
- States:
  - IDLE.
  - PH1: PHI2 low.
  - PH2: PHI2 high.
  - HOLD: PHI2 low, one Clk.
  - VPH1, VPH2, VHOLD: verify read, optional feature only.
  - DONE: Ack, one Clk.
- IDLE, Req=1 at edge N:
  - Latch ReqRW, ReqAddr and ReqWData.
  - Addr and RW update at N.
  - Busy=1 and the state moves to PH1; the counter loads PHASE_CLKS-1.
- PH1:
  - PHI2=0 and Addr/RW stable.
  - Counts down, then moves to PH2 with the counter reloaded.
- PH2:
  - PHI2=1 for exactly PHASE_CLKS Clks.
  - Write: DataOE=1 and DataOut=latched data for the whole of PH2 and HOLD.
  - Read: DataOE=0. DataIn is sampled into RData on the edge that ends PH2 (the same edge PHI2 falls).
- HOLD:
  - PHI2=0; Addr, RW and write data are held for one Clk, which gives hold time for the responder's negedge-strobe latches.
  - DataOE falls at the end of HOLD.
- DONE:
  - Ack=1 for one Clk and Busy=1.
  - The next state is IDLE, where Busy=0, RW returns to 1 and Addr holds its last value.
- Latency: Ack occurs 2*PHASE_CLKS+2 Clks after the accept edge. The minimum request-to-request spacing is 2*PHASE_CLKS+3 Clks, because one IDLE Clk always separates cycles.
- Req asserted outside IDLE is ignored and not queued. A Req held high is re-accepted in IDLE, which produces back-to-back cycles.
- Request inputs may change after the accept edge without effect.
- Addr wrap: $FFFF is a legal address; no increment logic.
- PHASE_CLKS outside 2..15 is a compile-time error via a generate-time check.

Optional Feature:
- Macro ATOM_BUS_VERIFY_EN.
- Defined:
  - Every write is followed automatically by a read of the same address: VPH1, VPH2, VHOLD, with the same timing as a read.
  - If the sampled data differs from the written data, VerifyErr is set and stays set until NReset.
  - Ack moves to the end of the verify cycle, so latency is 4*PHASE_CLKS+3.
  - RData is loaded with the read-back value.
- Undefined: the verify states are absent and VerifyErr is tied to 0.

Decomposition:
- Package atom_bus_pkg:
  - State enumeration.
  - Rombox register addresses: ROMLATCH_ADDR=16'hBFFF, SWLATCH_ADDR=16'hBFFE, JUMPER_ADDR=16'hBFFD.
  - RW_READ=1, RW_WRITE=0.
- Sub-module atom_phase_timer: a loadable down-counter with a terminal-count output, shared by all phase states.

Test Plan:
- Write $BFFF=8'h03 with PHASE_CLKS=4 and a responder model → PHI2 high exactly 4 Clks, DataOE high through HOLD, model latch=4'h3, Ack at accept+10, Busy low one Clk later.
- Read $BFFD with the model driving 8'h8C during PH2 → RData=8'h8C with Ack; DataOE never asserted.
- Req held high for 3 requests → 3 cycles separated by exactly one IDLE Clk each, 3 Ack pulses.
- NReset low during the 2nd Clk of PH2 of a write → PHI2=0 and DataOE=0 immediately, no Ack, model latch unchanged; the next request completes normally.
- PHASE_CLKS=2, write $0A00=8'h5A then read it back → Ack spacing 6 Clks, RData=8'h5A.
- With ATOM_BUS_VERIFY_EN, the model forces bit 0 low on reads; write $2000=8'hFF → VerifyErr=1, RData=8'hFE, Ack at accept+19.
